traffic_phase_arbiter: RTL and testbench
========================================

Name: traffic_phase_arbiter

Overview:
Phase scheduler for the five-approach intersection: e_left, e_str, w_left, w_str and ns. It latches sensor demand and grants three mutually exclusive phases in round-robin order: LEFT (e_left+w_left), STR (e_str+w_str) and NS. Each grant runs through a timed green/yellow/all-red sequence. Light outputs use the light_package colors type and drive the lamp drivers directly. Lights within one phase always share the same color.

Parameters:
MIN_GREEN, 5, minimum green cycles per grant
MAX_GREEN, 10, green cap in cycles when another phase has demand; must be >= MIN_GREEN
YELLOW_T, 2, yellow cycles
CLEAR_T, 1, all-red clearance cycles after yellow; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces the all-red idle state
e_left_sensor  in  1  eastbound left-turn demand
e_str_sensor  in  1  eastbound through demand
w_left_sensor  in  1  westbound left-turn demand
w_str_sensor  in  1  westbound through demand
ns_sensor  in  1  north-south demand
e_left_light  out  colors(2)  eastbound left arrow
e_str_light  out  colors(2)  eastbound through
w_left_light  out  colors(2)  westbound left arrow
w_str_light  out  colors(2)  westbound through
ns_light  out  colors(2)  north-south
phase_busy  out  1  1 whenever the FSM is not IDLE

Behaviour:
- Encoding: red=0, yellow=1, green=2. All light outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, all lights red, demand regs=0, timer=0, last_served=NS (so LEFT is checked first), phase_busy=0.
- Demand regs, one per phase:
  - demand[p] is set at an edge when any sensor of p is high and p is not currently in GREEN.
  - demand[p] is cleared on the edge entering GREEN for p.
  - demand[p] is not set while p is in GREEN.
- Phase selection: the first pending demand in the rotation after last_served (LEFT -> STR -> NS -> LEFT). last_served updates on GREEN entry.
- FSM states: IDLE, GREEN, YELLOW, CLEAR.
- IDLE:
  - Any demand set -> GREEN for the selected phase on the next edge; timer=1.
  - Latency: sensor sampled high at edge k; lights green after edge k+1.
- GREEN: timer increments each cycle and saturates at MAX_GREEN. Exit to YELLOW when either condition holds:
  - (a) timer >= MIN_GREEN and all own sensors are low;
  - (b) timer >= MAX_GREEN and another phase has demand.
  - Own sensors held high with no other demand keep the phase green indefinitely.
- YELLOW: runs YELLOW_T cycles, then -> CLEAR. On the YELLOW entry edge, demand for the outgoing phase is set if its sensors are still high.
- CLEAR: all red for CLEAR_T cycles. Then -> GREEN for the next selected phase, or -> IDLE if no demand.
- Safety invariants, checked every cycle:
  - Lights of different phases are never non-red simultaneously.
  - Every green->red change passes through YELLOW_T yellow cycles and then CLEAR_T all-red cycles.
- Simultaneous demand on all three phases serves LEFT, then STR, then NS, each capped at MAX_GREEN.
- Sensor glitch shorter than one cycle between edges: ignored.
- Reset asserted mid-GREEN or mid-YELLOW: lights go red immediately and asynchronously. No yellow is issued. Demand is lost.

Optional Feature:
EMERGENCY_PREEMPT_EN
- When defined, two ports are added: emerg_req (in, 1) and emerg_phase (in, 2; 0=LEFT, 1=STR, 2=NS, 3=ignored).
- emerg_req=1 with a valid emerg_phase:
  - If the current green phase differs from emerg_phase, it goes to YELLOW immediately, ignoring MIN_GREEN.
  - After CLEAR, emerg_phase is granted green regardless of the rotation.
  - It holds green while emerg_req=1; the MAX_GREEN cap is disabled.
  - On emerg_req release, normal rules resume. last_served becomes emerg_phase.
- emerg_req during YELLOW/CLEAR only redirects the next grant; the sequence is not shortened.
- When the macro is undefined, the ports are absent and behaviour is exactly as above.

Test Plan:
1. Reset low 2 cycles, then high, no sensors -> all lights red, phase_busy=0 for 20 cycles.
2. e_left_sensor=1 for 1 cycle at edge 3 -> e_left/w_left green edges 4-8 (5 cycles), yellow 2 cycles, red 1 cycle, then IDLE. All other lights red throughout.
3. ns_sensor held high with no other demand -> ns green continuously for 30 cycles. Then e_str_sensor=1 -> ns green stops after timer reaches 10, yellow 2, red 1, then e_str/w_str green.
4. All five sensors high for 100 cycles -> grants LEFT, STR, NS in order, each green 10 cycles, yellow 2, clear 1; rotation repeats. No cross-phase non-red overlap.
5. Reset asserted on the third green cycle of STR -> all lights red combinationally before the next edge. After release with sensors low, the block stays IDLE.
6. (EMERGENCY_PREEMPT_EN) LEFT green at timer=2, emerg_req=1 with emerg_phase=2 -> LEFT yellow next cycle, ns green after 2 yellow + 1 red cycles, held 15 cycles while asserted.

Source files
------------

// File: rtl/traffic_phase_arbiter.sv
// Round-robin phase scheduler for a five-approach intersection (LEFT, STR, NS).
// Optional emergency preemption is enabled with `define EMERGENCY_PREEMPT_EN.
package light_package;
  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} colors;
endpackage

module traffic_phase_arbiter
  import light_package::*;
#(
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned CLEAR_T   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_left_sensor,
  input  logic       e_str_sensor,
  input  logic       w_left_sensor,
  input  logic       w_str_sensor,
  input  logic       ns_sensor,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic [1:0] emerg_phase,
`endif
  output colors      e_left_light,
  output colors      e_str_light,
  output colors      w_left_light,
  output colors      w_str_light,
  output colors      ns_light,
  output logic       phase_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_GREEN, ST_YELLOW, ST_CLEAR} state_t;
  typedef enum logic [1:0] {PH_LEFT = 2'd0, PH_STR = 2'd1, PH_NS = 2'd2} phase_t;

  localparam logic [7:0] L_MIN = 8'(MIN_GREEN);
  localparam logic [7:0] L_MAX = 8'(MAX_GREEN);
  localparam logic [7:0] L_YEL = 8'(YELLOW_T);
  localparam logic [7:0] L_CLR = 8'(CLEAR_T);

  state_t     r_state;
  phase_t     r_phase;
  phase_t     r_last;
  logic [7:0] r_timer;
  logic [2:0] r_demand;
  colors      r_col_left, r_col_str, r_col_ns;

  logic [3:0] w_sens;
  logic [2:0] w_pick;
  logic       w_em_valid;
  phase_t     w_em_phase;
  logic       w_next_valid;
  phase_t     w_next_ph;
  logic       w_green_exit;
  logic       w_enter;
  logic [2:0] w_others;
  logic [2:0] w_demand_nxt;

  // First pending phase after last_served; later rotation slots are overridden by earlier ones.
  function automatic logic [2:0] f_pick(input logic [2:0] dem, input phase_t last);
    logic [1:0] p;
    int unsigned t;
    f_pick = '0;
    for (int unsigned i = 3; i >= 1; i--) begin
      t = (32'(last) + i) % 3;
      p = 2'(t);
      if (dem[p]) f_pick = {1'b1, p};
    end
  endfunction

  function automatic colors f_col(input phase_t ph, input phase_t tgt, input colors c);
    return (ph == tgt) ? c : RED;
  endfunction

`ifdef EMERGENCY_PREEMPT_EN
  assign w_em_valid = emerg_req && (emerg_phase != 2'd3);
  assign w_em_phase = phase_t'(emerg_phase);
`else
  assign w_em_valid = 1'b0;
  assign w_em_phase = PH_LEFT;
`endif

  assign w_sens       = {1'b0, ns_sensor, e_str_sensor | w_str_sensor, e_left_sensor | w_left_sensor};
  assign w_pick       = f_pick(r_demand, r_last);
  assign w_next_valid = w_em_valid | w_pick[2];
  assign w_next_ph    = w_em_valid ? w_em_phase : phase_t'(w_pick[1:0]);
  assign w_others     = r_demand & ~(3'b001 << r_phase);

  assign w_green_exit = (r_state == ST_GREEN) &&
                        (w_em_valid ? (w_em_phase != r_phase)
                                    : ((r_timer >= L_MIN && !w_sens[r_phase]) ||
                                       (r_timer >= L_MAX && |w_others)));

  assign w_enter = w_next_valid &&
                   ((r_state == ST_IDLE) || (r_state == ST_CLEAR && r_timer >= L_CLR));

  // The outgoing phase re-latches its own sensors on the edge it leaves GREEN.
  always_comb begin
    w_demand_nxt = r_demand;
    for (int unsigned p = 0; p < 3; p++) begin
      if (w_enter && (32'(w_next_ph) == p))
        w_demand_nxt[p] = 1'b0;
      else if (w_sens[p] && !(r_state == ST_GREEN && 32'(r_phase) == p && !w_green_exit))
        w_demand_nxt[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_LEFT;
      r_last     <= PH_NS;
      r_timer    <= '0;
      r_demand   <= '0;
      r_col_left <= RED;
      r_col_str  <= RED;
      r_col_ns   <= RED;
      phase_busy <= 1'b0;
    end else begin
      r_demand <= w_demand_nxt;
      if (w_enter) begin
        r_state    <= ST_GREEN;
        r_phase    <= w_next_ph;
        r_last     <= w_next_ph;
        r_timer    <= 8'd1;
        phase_busy <= 1'b1;
        r_col_left <= f_col(w_next_ph, PH_LEFT, GREEN);
        r_col_str  <= f_col(w_next_ph, PH_STR, GREEN);
        r_col_ns   <= f_col(w_next_ph, PH_NS, GREEN);
      end else begin
        unique case (r_state)
          ST_IDLE: r_timer <= '0;
          ST_GREEN: begin
            if (w_green_exit) begin
              r_state    <= ST_YELLOW;
              r_timer    <= 8'd1;
              r_col_left <= f_col(r_phase, PH_LEFT, YELLOW);
              r_col_str  <= f_col(r_phase, PH_STR, YELLOW);
              r_col_ns   <= f_col(r_phase, PH_NS, YELLOW);
            end else if (r_timer < L_MAX) begin
              r_timer <= r_timer + 8'd1;
            end
          end
          ST_YELLOW: begin
            if (r_timer >= L_YEL) begin
              r_state    <= ST_CLEAR;
              r_timer    <= 8'd1;
              r_col_left <= RED;
              r_col_str  <= RED;
              r_col_ns   <= RED;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
          ST_CLEAR: begin
            if (r_timer >= L_CLR) begin
              r_state    <= ST_IDLE;
              r_timer    <= '0;
              phase_busy <= 1'b0;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign e_left_light = r_col_left;
  assign w_left_light = r_col_left;
  assign e_str_light  = r_col_str;
  assign w_str_light  = r_col_str;
  assign ns_light     = r_col_ns;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_traffic_phase_arbiter;
  import light_package::*;

  localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2;
  localparam logic [4:0] S_EL = 5'b10000, S_ES = 5'b01000, S_WL = 5'b00100,
                         S_WS = 5'b00010, S_NS = 5'b00001, S_NONE = 5'b00000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic e_left_sensor = 1'b0, e_str_sensor = 1'b0, w_left_sensor = 1'b0;
  logic w_str_sensor = 1'b0, ns_sensor = 1'b0;
  colors e_left_light, e_str_light, w_left_light, w_str_light, ns_light;
  logic phase_busy;

  int nerr = 0;
  int nchk = 0;

  traffic_phase_arbiter #(.MIN_GREEN(5), .MAX_GREEN(10), .YELLOW_T(2), .CLEAR_T(1)) dut (
    .clk(clk), .reset(reset),
    .e_left_sensor(e_left_sensor), .e_str_sensor(e_str_sensor),
    .w_left_sensor(w_left_sensor), .w_str_sensor(w_str_sensor), .ns_sensor(ns_sensor),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req(1'b0), .emerg_phase(2'd3),
`endif
    .e_left_light(e_left_light), .e_str_light(e_str_light),
    .w_left_light(w_left_light), .w_str_light(w_str_light),
    .ns_light(ns_light), .phase_busy(phase_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sens;
    logic [1:0] l, s, n;
    logic       busy;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [1:0] el, input logic [1:0] es,
                     input logic [1:0] en, input logic eb);
    logic [6:0] act, exp;
    act = {e_left_light, e_str_light, ns_light, phase_busy};
    exp = {el, es, en, eb};
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t: got {left,str,ns,busy}=%b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] s);
    {e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor} = s;
  endtask

  task automatic step(input logic [4:0] s);
    @(negedge clk);
    drive(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(S_NONE);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", R, R, R, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Lamp safety monitor: paired approaches agree and at most one phase is non-red.
  always @(negedge clk) begin
    nchk++;
    if (e_left_light !== w_left_light || e_str_light !== w_str_light ||
        (int'(e_left_light != RED) + int'(e_str_light != RED) + int'(ns_light != RED)) > 1) begin
      nerr++;
      $display("FAIL safety t=%0t: el=%0d wl=%0d es=%0d ws=%0d ns=%0d", $time,
               e_left_light, w_left_light, e_str_light, w_str_light, ns_light);
    end
  end

  function automatic logic [6:0] all_model(input int c);
    int pos, ph;
    logic [1:0] col;
    if (c < 2) return {R, R, R, 1'b0};
    pos = (c - 2) % 13;
    ph  = ((c - 2) / 13) % 3;
    col = (pos < 10) ? G : (pos < 12) ? Y : R;
    return {(ph == 0) ? col : R, (ph == 1) ? col : R, (ph == 2) ? col : R, 1'b1};
  endfunction

  initial begin
    // Idle after reset, then a one-cycle e_left pulse: 5 green, 2 yellow, 1 clear, idle.
    vt[0]  = '{S_NONE, R, R, R, 1'b0};
    vt[1]  = '{S_NONE, R, R, R, 1'b0};
    vt[2]  = '{S_NONE, R, R, R, 1'b0};
    vt[3]  = '{S_NONE, R, R, R, 1'b0};
    vt[4]  = '{S_EL,   R, R, R, 1'b0};
    vt[5]  = '{S_NONE, G, R, R, 1'b1};
    vt[6]  = '{S_NONE, G, R, R, 1'b1};
    vt[7]  = '{S_NONE, G, R, R, 1'b1};
    vt[8]  = '{S_NONE, G, R, R, 1'b1};
    vt[9]  = '{S_NONE, G, R, R, 1'b1};
    vt[10] = '{S_NONE, Y, R, R, 1'b1};
    vt[11] = '{S_NONE, Y, R, R, 1'b1};
    vt[12] = '{S_NONE, R, R, R, 1'b1};
    vt[13] = '{S_NONE, R, R, R, 1'b0};
    vt[14] = '{S_NONE, R, R, R, 1'b0};
    vt[15] = '{S_NONE, R, R, R, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(vt[i].sens);
      chk($sformatf("vec%0d", i), vt[i].l, vt[i].s, vt[i].n, vt[i].busy);
    end
    for (int i = 0; i < 16; i++) begin
      step(S_NONE);
      chk("idle_hold", R, R, R, 1'b0);
    end

    // Sub-cycle glitch between edges is never sampled.
    @(negedge clk);
    #1 e_left_sensor = 1'b1;
    #2 e_left_sensor = 1'b0;
    step(S_NONE);
    chk("glitch_ignored", R, R, R, 1'b0);
    step(S_NONE);
    chk("glitch_ignored2", R, R, R, 1'b0);

    // NS held alone stays green; e_str then forces yellow once the cap is reached.
    do_reset();
    step(S_NS);
    chk("ns_latch", R, R, R, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(S_NS);
      chk("ns_hold", R, R, G, 1'b1);
    end
    step(S_NS | S_ES);  chk("ns_demand_seen", R, R, G, 1'b1);
    step(S_NS | S_ES);  chk("ns_yellow1", R, R, Y, 1'b1);
    step(S_NS | S_ES);  chk("ns_yellow2", R, R, Y, 1'b1);
    step(S_NS | S_ES);  chk("ns_clear", R, R, R, 1'b1);
    step(S_NS);         chk("str_enter", R, G, R, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(S_NS);
      chk("str_min_green", R, G, R, 1'b1);
    end
    step(S_NS);         chk("str_yellow1", R, Y, R, 1'b1);
    step(S_NS);         chk("str_yellow2", R, Y, R, 1'b1);
    step(S_NS);         chk("str_clear", R, R, R, 1'b1);
    step(S_NS);         chk("ns_regrant", R, R, G, 1'b1);

    // All sensors high: LEFT, STR, NS in rotation, each capped at 10 green cycles.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      logic [6:0] e;
      step(S_EL | S_ES | S_WL | S_WS | S_NS);
      e = all_model(c);
      chk($sformatf("rr_c%0d", c), e[6:5], e[4:3], e[2:1], e[0]);
    end

    // Reset on the third STR green cycle with NS demand pending: lamps drop at once, demand lost.
    do_reset();
    step(S_WS);         chk("str_latch", R, R, R, 1'b0);
    step(S_WS);         chk("str_g1", R, G, R, 1'b1);
    step(S_WS | S_NS);  chk("str_g2", R, G, R, 1'b1);
    step(S_WS);         chk("str_g3", R, G, R, 1'b1);
    #2 reset = 1'b0;
    #1 chk("async_reset", R, R, R, 1'b0);
    drive(S_NONE);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(S_NONE);
      chk("post_reset_idle", R, R, R, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
